morse_blinker: RTL
==================

MORSE_BLINKER -- requirements
Module: morse_blinker

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 12500000, clocks per Morse time unit (250 ms at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter MSG_LEN, default 12, number of 2-bit symbols in the message; legal range 1..64.
REQ-003 SHALL have parameter MSG, default 24'b11_00_00_00_10_01_01_01_10_00_00_00 (SOS + word gap), packed symbols, symbol 0 in bits [1:0].
REQ-004 SHALL have parameter LED_ACTIVE_HIGH, default 1; 0 inverts the led output.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle request to begin the message from symbol 0.
REQ-008 stop  input  1  abort request, returns block to idle.
REQ-009 repeat_en  input  1  level; 1 = loop message continuously.
REQ-010 led  output  1  registered LED drive (polarity per LED_ACTIVE_HIGH).
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse on non-repeating message completion.
REQ-013 sym_idx  output  6  index of symbol currently being played.

Function
REQ-014 Symbol codes SHALL be: 00 dot = 1 unit lit; 01 dash = 3 units lit; 10 letter gap = 2 units dark; 11 word gap = 6 units dark.
REQ-015 Every dot and dash SHALL be followed by exactly 1 dark unit (intra-letter gap), so letter gap totals 3 and word gap totals 7 dark units after a mark.
REQ-016 State machine SHALL have states IDLE, MARK, SPACE, GAP.
REQ-017 IDLE -> MARK (dot/dash) or GAP (10/11) on the clock edge where start=1; sym_idx=0 on that edge.
REQ-018 MARK SHALL last 1 or 3 units, then -> SPACE for 1 unit; GAP SHALL last 2 or 6 units.
REQ-019 At end of SPACE or GAP: if sym_idx < MSG_LEN-1, increment sym_idx and enter state for next symbol on the same edge (no dead cycle).
REQ-020 At end of last symbol: repeat_en sampled on that edge; 1 -> sym_idx=0 and play symbol 0 with no dead cycle; 0 -> IDLE and done=1 for exactly the following cycle.
REQ-021 A unit SHALL be exactly UNIT_CYCLES clocks; unit counter and units-remaining counter reload on every state entry.
REQ-022 led SHALL be lit on every clock cycle the state is MARK and dark otherwise, lit from the first cycle after the entering edge.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 stop=1 SHALL force IDLE on the next edge from any state, led dark, sym_idx=0, no done pulse; stop has priority over start in the same cycle.
REQ-025 Counters SHALL be sized $clog2 of their maximum; no wrap-around other than the defined reload.

Reset
REQ-026 While rst=0: state IDLE, led dark (0 if LED_ACTIVE_HIGH=1, else 1), busy=0, done=0, sym_idx=0, all counters 0.
REQ-027 Reset deassertion SHALL not start playback; a start pulse is required.
REQ-028 Reset asserted mid-message SHALL take effect immediately and asynchronously, with no done pulse.

Verification (UNIT_CYCLES=4, defaults otherwise)
REQ-029 Start pulse -> led lit 4 cycles, dark 4, ×3 dots; letter gap dark total 12; dash lit 12; full SOS 136 cycles ending at IDLE, then done pulse for exactly 1 cycle.
REQ-030 repeat_en=1 then start -> second pass begins immediately after the 28-cycle word gap with sym_idx=0, no done pulse; drop repeat_en -> done after that pass.
REQ-031 stop mid-dash (sym_idx=5) -> next cycle busy=0, led=0, sym_idx=0, done never pulses.
REQ-032 start pulsed while busy at sym_idx=3 -> timing and sequence unchanged versus REQ-029.
REQ-033 rst=0 for 1 cycle mid-message -> led=0, busy=0 immediately; no activity until next start.
REQ-034 LED_ACTIVE_HIGH=0 -> led waveform is exact inverse of REQ-029, led=1 in reset and idle.

Source files
------------

// File: rtl/morse_blinker.sv
// Morse code LED blinker: plays a packed 2-bit symbol message
// with dot/dash/gap timing in units of UNIT_CYCLES clocks.
module morse_blinker #(
    parameter int                   UNIT_CYCLES     = 12500000,
    parameter int                   MSG_LEN         = 12,
    parameter logic [2*MSG_LEN-1:0] MSG             = 24'b11_00_00_00_10_01_01_01_10_00_00_00,
    parameter bit                   LED_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       repeat_en,
    output logic       led,
    output logic       busy,
    output logic       done,
    output logic [5:0] sym_idx
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(UNIT_CYCLES - 1);
    localparam logic [5:0]    LAST    = 6'(MSG_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MARK  = 2'd1;
    localparam logic [1:0] S_SPACE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_units;
    logic [5:0]    r_idx;
    logic          r_led;
    logic          r_done;

    logic [1:0]    w_state_n;
    logic [CW-1:0] w_cnt_n;
    logic [2:0]    w_units_n;
    logic [5:0]    w_idx_n;
    logic          w_done_n;
    logic [5:0]    w_tgt_idx;
    logic [1:0]    w_code;
    logic [1:0]    w_ent_state;
    logic [2:0]    w_ent_units;

    function automatic logic [1:0] sym_code(input logic [5:0] i);
        return 2'(MSG >> {i, 1'b0});
    endfunction

    // Symbol that would be entered next: 0 from idle or after the last one
    always_comb begin
        w_tgt_idx = '0;
        if (r_state != S_IDLE && r_idx != LAST)
            w_tgt_idx = r_idx + 6'd1;
        w_code      = sym_code(w_tgt_idx);
        w_ent_state = w_code[1] ? S_GAP : S_MARK;
        w_ent_units = 3'd0;
        unique case (w_code)
            2'b00: w_ent_units = 3'd0;
            2'b01: w_ent_units = 3'd2;
            2'b10: w_ent_units = 3'd1;
            2'b11: w_ent_units = 3'd5;
            default: w_ent_units = 3'd0;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_units_n = r_units;
        w_idx_n   = r_idx;
        w_done_n  = 1'b0;
        if (stop) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_units_n = '0;
            w_idx_n   = '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                w_state_n = w_ent_state;
                w_cnt_n   = CNT_TOP;
                w_units_n = w_ent_units;
                w_idx_n   = '0;
            end
        end else if (r_cnt != '0) begin
            w_cnt_n = r_cnt - CW'(1);
        end else if (r_units != '0) begin
            w_units_n = r_units - 3'd1;
            w_cnt_n   = CNT_TOP;
        end else if (r_state == S_MARK) begin
            w_state_n = S_SPACE;
            w_cnt_n   = CNT_TOP;
            w_units_n = '0;
        end else if (r_idx != LAST || repeat_en) begin
            w_state_n = w_ent_state;
            w_cnt_n   = CNT_TOP;
            w_units_n = w_ent_units;
            w_idx_n   = w_tgt_idx;
        end else begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_units_n = '0;
            w_idx_n   = '0;
            w_done_n  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_units <= '0;
            r_idx   <= '0;
            r_led   <= ~LED_ACTIVE_HIGH;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_units <= w_units_n;
            r_idx   <= w_idx_n;
            r_led   <= (w_state_n == S_MARK) ^ ~LED_ACTIVE_HIGH;
            r_done  <= w_done_n;
        end
    end

    assign led     = r_led;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign sym_idx = r_idx;

endmodule
